// File: rtl/fust_issue.sv
// FU status table with in-order-free wakeup and lowest-index-first issue for five FUs.
// Optional FUST_WB_BYPASS_EN: dispatch tags matching a same-cycle writeback are captured already woken.
module fust_issue (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            disp_en,
    input  logic [2:0]      disp_fu,
    input  logic [4:0]      disp_rd,
    input  logic [3:0]      disp_t1,
    input  logic [3:0]      disp_t2,
    output logic            disp_ack,
    input  logic [4:0]      fu_ex,
    input  logic            wb_en,
    input  logic [2:0]      wb_fu,
    input  logic            branch_miss,
    output logic [4:0][1:0] fust_state,
    output logic            issue_en,
    output logic [2:0]      issue_fu,
    output logic [4:0]      issue_rd
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        READY = 2'd2,
        EXEC  = 2'd3
    } state_t;

    state_t     state_reg [5];
    logic [4:0] rd_reg    [5];
    logic [3:0] t1_reg    [5];
    logic [3:0] t2_reg    [5];

    logic       wb_valid;
    logic       t1_live, t2_live, t1_hit, t2_hit;
    logic [3:0] cap_t1, cap_t2;
    logic       cfg_ok;
    logic [4:0] disp_sel, entry_idle, entry_ready, issue_sel;

    assign wb_valid = wb_en && (wb_fu < 3'd5);

    // A tag naming a nonexistent FU can never be woken, so it is treated as already satisfied.
    assign t1_live = disp_t1[3] && (disp_t1[2:0] < 3'd5);
    assign t2_live = disp_t2[3] && (disp_t2[2:0] < 3'd5);
    assign t1_hit  = wb_valid && (disp_t1[2:0] == wb_fu);
    assign t2_hit  = wb_valid && (disp_t2[2:0] == wb_fu);

`ifdef FUST_WB_BYPASS_EN
    assign cap_t1 = {t1_live && !t1_hit, disp_t1[2:0]};
    assign cap_t2 = {t2_live && !t2_hit, disp_t2[2:0]};
    assign cfg_ok = 1'b1;
`else
    // Without bypass the wakeup would be lost, so the dispatch must retry.
    assign cap_t1 = {t1_live, disp_t1[2:0]};
    assign cap_t2 = {t2_live, disp_t2[2:0]};
    assign cfg_ok = !((t1_live && t1_hit) || (t2_live && t2_hit));
`endif

    assign disp_ack = nRST && disp_en && !branch_miss && cfg_ok && |(disp_sel & entry_idle);

    always_comb begin
        issue_en = 1'b0;
        issue_fu = 3'd0;
        issue_rd = 5'd0;
        for (int i = 4; i >= 0; i--) begin
            if (!branch_miss && entry_ready[i] && fu_ex[i]) begin
                issue_en = 1'b1;
                issue_fu = 3'(i);
                issue_rd = rd_reg[i];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_entry
            state_t     state_next;
            logic [4:0] rd_next;
            logic [3:0] t1_wb, t2_wb, t1_next, t2_next;
            logic       wb_here;

            assign disp_sel[gi]    = (disp_fu == 3'(gi));
            assign entry_idle[gi]  = (state_reg[gi] == IDLE);
            assign entry_ready[gi] = (state_reg[gi] == READY);
            assign issue_sel[gi]   = issue_en && (issue_fu == 3'(gi));
            assign fust_state[gi]  = state_reg[gi];
            assign wb_here         = wb_en && (wb_fu == 3'(gi));

            always_comb begin
                t1_wb = t1_reg[gi];
                t2_wb = t2_reg[gi];
                if (wb_valid && t1_reg[gi][2:0] == wb_fu) t1_wb[3] = 1'b0;
                if (wb_valid && t2_reg[gi][2:0] == wb_fu) t2_wb[3] = 1'b0;

                state_next = state_reg[gi];
                rd_next    = rd_reg[gi];
                t1_next    = t1_wb;
                t2_next    = t2_wb;

                // Priority: flush, then issue (beats a same-cycle wb), then dispatch, then wb/wakeup.
                if (branch_miss) begin
                    if (state_reg[gi] != EXEC || wb_here) state_next = IDLE;
                end else if (issue_sel[gi]) begin
                    state_next = EXEC;
                end else if (disp_ack && disp_sel[gi]) begin
                    rd_next    = disp_rd;
                    t1_next    = cap_t1;
                    t2_next    = cap_t2;
                    state_next = (cap_t1[3] || cap_t2[3]) ? PEND : READY;
                end else if (state_reg[gi] == EXEC && wb_here) begin
                    state_next = IDLE;
                end else if (state_reg[gi] == PEND && !t1_wb[3] && !t2_wb[3]) begin
                    state_next = READY;
                end
            end

            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    state_reg[gi] <= IDLE;
                    rd_reg[gi]    <= 5'd0;
                    t1_reg[gi]    <= 4'd0;
                    t2_reg[gi]    <= 4'd0;
                end else begin
                    state_reg[gi] <= state_next;
                    rd_reg[gi]    <= rd_next;
                    t1_reg[gi]    <= t1_next;
                    t2_reg[gi]    <= t2_next;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fust_issue.sv
// Directed bench for fust_issue; issue traffic is checked against a queue of expected {fu, rd}.
module tb_fust_issue;

    logic            CLK = 1'b0;
    logic            nRST;
    logic            disp_en;
    logic [2:0]      disp_fu;
    logic [4:0]      disp_rd;
    logic [3:0]      disp_t1, disp_t2;
    logic            disp_ack;
    logic [4:0]      fu_ex;
    logic            wb_en;
    logic [2:0]      wb_fu;
    logic            branch_miss;
    logic [4:0][1:0] fust_state;
    logic            issue_en;
    logic [2:0]      issue_fu;
    logic [4:0]      issue_rd;

    localparam int S_IDLE = 0, S_PEND = 1, S_READY = 2, S_EXEC = 3;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    logic [7:0] exp_q [$];

    fust_issue dut (
        .CLK(CLK), .nRST(nRST),
        .disp_en(disp_en), .disp_fu(disp_fu), .disp_rd(disp_rd),
        .disp_t1(disp_t1), .disp_t2(disp_t2), .disp_ack(disp_ack),
        .fu_ex(fu_ex), .wb_en(wb_en), .wb_fu(wb_fu), .branch_miss(branch_miss),
        .fust_state(fust_state),
        .issue_en(issue_en), .issue_fu(issue_fu), .issue_rd(issue_rd)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample issue outputs mid-cycle, score them, then advance one edge.
    task automatic tick();
        logic [7:0] e;
        #1;
        if (issue_en === 1'b1) begin
            n_total++;
            assert (exp_q.size() != 0) n_pass++;
            else begin
                n_fail++;
                $error("FAIL issue_unexpected observed fu=%0d rd=%0d expected none", issue_fu, issue_rd);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("issue_fu", 32'(issue_fu), 32'(e[7:5]));
                chk("issue_rd", 32'(issue_rd), 32'(e[4:0]));
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic disp(input logic [2:0] fu, input logic [4:0] rd,
                        input logic [3:0] t1, input logic [3:0] t2);
        disp_en = 1'b1; disp_fu = fu; disp_rd = rd; disp_t1 = t1; disp_t2 = t2;
    endtask

    task automatic idle_in();
        disp_en = 1'b0; disp_fu = 3'd0; disp_rd = 5'd0; disp_t1 = 4'd0; disp_t2 = 4'd0;
        wb_en = 1'b0; wb_fu = 3'd0; branch_miss = 1'b0; fu_ex = 5'd0;
    endtask

    initial begin
        idle_in();
        nRST = 1'b0;
        disp(3'd0, 5'd1, 4'd0, 4'd0);
        fu_ex = 5'b11111;
        @(posedge CLK);
        #2;
        chk("rst_state", 32'(fust_state), 32'd0);
        chk("rst_issue_en", 32'(issue_en), 32'd0);
        chk("rst_issue_fu", 32'(issue_fu), 32'd0);
        chk("rst_issue_rd", 32'(issue_rd), 32'd0);
        chk("rst_disp_ack", 32'(disp_ack), 32'd0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        idle_in();

        // Basic dispatch -> READY -> issue -> EXEC on entry 2
        disp(3'd2, 5'd7, 4'd0, 4'd0);
        fu_ex = 5'b11111;
        #1;
        chk("b_ack", 32'(disp_ack), 32'd1);
        exp_q.push_back({3'd2, 5'd7});
        tick();
        disp_en = 1'b0;
        chk("b_ready", 32'(fust_state[2]), S_READY);
        tick();
        chk("b_exec", 32'(fust_state[2]), S_EXEC);
        fu_ex = 5'd0;

        // Entry 1 to EXEC, then entry 3 waits on FU1 writeback
        disp(3'd1, 5'd3, 4'd0, 4'd0);
        fu_ex = 5'b00010;
        exp_q.push_back({3'd1, 5'd3});
        tick();
        disp_en = 1'b0;
        tick();
        chk("w_e1_exec", 32'(fust_state[1]), S_EXEC);
        fu_ex = 5'd0;
        disp(3'd3, 5'd9, 4'b1001, 4'd0);
        #1;
        chk("w_ack", 32'(disp_ack), 32'd1);
        tick();
        disp_en = 1'b0;
        chk("w_pend", 32'(fust_state[3]), S_PEND);
        tick();
        chk("w_still_pend", 32'(fust_state[3]), S_PEND);
        wb_en = 1'b1; wb_fu = 3'd1; fu_ex = 5'b01000;
        exp_q.push_back({3'd3, 5'd9});
        tick();
        wb_en = 1'b0;
        chk("w_e1_idle", 32'(fust_state[1]), S_IDLE);
        chk("w_ready", 32'(fust_state[3]), S_READY);
        tick();
        chk("w_exec", 32'(fust_state[3]), S_EXEC);
        fu_ex = 5'd0;

        // Entries 0 and 4 READY: lowest index issues first
        disp(3'd0, 5'd10, 4'd0, 4'd0);
        tick();
        disp(3'd4, 5'd20, 4'd0, 4'd0);
        tick();
        disp_en = 1'b0;
        fu_ex = 5'b10001;
        exp_q.push_back({3'd0, 5'd10});
        exp_q.push_back({3'd4, 5'd20});
        tick();
        chk("p_e0_exec", 32'(fust_state[0]), S_EXEC);
        chk("p_e4_ready", 32'(fust_state[4]), S_READY);
        tick();
        chk("p_e4_exec", 32'(fust_state[4]), S_EXEC);
        fu_ex = 5'd0;

        // Dispatch into an entry completing this cycle is rejected
        wb_en = 1'b1; wb_fu = 3'd0;
        disp(3'd0, 5'd11, 4'd0, 4'd0);
        #1;
        chk("x_ack", 32'(disp_ack), 32'd0);
        tick();
        disp_en = 1'b0;
        chk("x_e0_idle", 32'(fust_state[0]), S_IDLE);
        wb_fu = 3'd4;
        tick();
        wb_fu = 3'd2;
        tick();
        wb_en = 1'b0;
        chk("x_after_wb", 32'(fust_state), 32'({2'd0, 2'd3, 2'd0, 2'd0, 2'd0}));

        // Branch flush: 1 PEND, 2 READY, 3 EXEC
        disp(3'd1, 5'd5, 4'b1011, 4'd0);
        tick();
        disp(3'd2, 5'd6, 4'd0, 4'd0);
        tick();
        chk("f_pre", 32'(fust_state), 32'({2'd0, 2'd3, 2'd2, 2'd1, 2'd0}));
        branch_miss = 1'b1; fu_ex = 5'b11111;
        disp(3'd0, 5'd12, 4'd0, 4'd0);
        #1;
        chk("f_issue_en", 32'(issue_en), 32'd0);
        chk("f_ack", 32'(disp_ack), 32'd0);
        tick();
        idle_in();
        chk("f_e1", 32'(fust_state[1]), S_IDLE);
        chk("f_e2", 32'(fust_state[2]), S_IDLE);
        chk("f_e3", 32'(fust_state[3]), S_EXEC);
        chk("f_e0", 32'(fust_state[0]), S_IDLE);
        wb_en = 1'b1; wb_fu = 3'd3;
        tick();
        wb_en = 1'b0;
        chk("f_e3_idle", 32'(fust_state[3]), S_IDLE);

        // Dispatch with a tag matching a same-cycle writeback
        wb_en = 1'b1; wb_fu = 3'd0;
        disp(3'd0, 5'd13, 4'b1000, 4'd0);
        #1;
`ifdef FUST_WB_BYPASS_EN
        chk("y_ack", 32'(disp_ack), 32'd1);
`else
        chk("y_ack", 32'(disp_ack), 32'd0);
`endif
        tick();
        idle_in();
`ifdef FUST_WB_BYPASS_EN
        chk("y_state", 32'(fust_state[0]), S_READY);
`else
        chk("y_state", 32'(fust_state[0]), S_IDLE);
`endif
        branch_miss = 1'b1;
        tick();
        branch_miss = 1'b0;
        chk("y_flushed", 32'(fust_state), 32'd0);

        // Rejected dispatches leave the table untouched
        disp(3'd3, 5'd1, 4'd0, 4'd0);
        tick();
        disp(3'd3, 5'd2, 4'b1100, 4'd0);
        #1;
        chk("r_busy_ack", 32'(disp_ack), 32'd0);
        disp(3'd6, 5'd3, 4'd0, 4'd0);
        #1;
        chk("r_bad_fu_ack", 32'(disp_ack), 32'd0);
        tick();
        disp_en = 1'b0;
        chk("r_table", 32'(fust_state), 32'({2'd0, 2'd2, 2'd0, 2'd0, 2'd0}));
        fu_ex = 5'b01000;
        exp_q.push_back({3'd3, 5'd1});
        tick();
        fu_ex = 5'd0;
        chk("r_exec", 32'(fust_state[3]), S_EXEC);

        // Pending tag on a nonexistent FU is captured as satisfied
        disp(3'd4, 5'd14, 4'd0, 4'b1111);
        tick();
        disp_en = 1'b0;
        chk("g_ready", 32'(fust_state[4]), S_READY);

        // Asynchronous reset mid-operation
        fu_ex = 5'b11111;
        exp_q.push_back({3'd4, 5'd14});
        nRST = 1'b0;
        #1;
        void'(exp_q.pop_back());
        chk("m_state", 32'(fust_state), 32'd0);
        chk("m_issue_en", 32'(issue_en), 32'd0);
        tick();
        nRST = 1'b1;
        fu_ex = 5'd0;

        disp(3'd0, 5'd31, 4'd0, 4'd0);
        tick();
        disp_en = 1'b0;
        fu_ex = 5'b00001;
        exp_q.push_back({3'd0, 5'd31});
        tick();
        chk("z_exec", 32'(fust_state[0]), S_EXEC);
        chk("z_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
